// File: rtl/acc_sha256_pkg.sv
// acc_sha256_pkg: SHA-256 round constants, IV, FSM states, working-variable struct and round helpers.
package acc_sha256_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
   // Packed so that {a..h} lines up with H0..H7 with a at [255:224]
   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } work_t;
   localparam logic [255:0] SHA256_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction
   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction
endpackage

// File: rtl/acc_sha256_compressor_round.sv
// acc_sha256_round: combinational single SHA-256 round {a..h, K, W} -> {a'..h'}.
module acc_sha256_round
   import acc_sha256_pkg::*;
(
   input  work_t       wv_i,
   input  logic [31:0] k_i,
   input  logic [31:0] w_i,
   output work_t       wv_o
);
   logic [31:0] t1, t2;
   assign t1 = wv_i.h + big_sigma1(wv_i.e) + ch(wv_i.e, wv_i.f, wv_i.g) + k_i + w_i;
   assign t2 = big_sigma0(wv_i.a) + maj(wv_i.a, wv_i.b, wv_i.c);
   assign wv_o = '{a: t1 + t2, b: wv_i.a, c: wv_i.b, d: wv_i.c, e: wv_i.d + t1, f: wv_i.e, g: wv_i.f, h: wv_i.g};
endmodule

// File: rtl/acc_sha256_compressor.sv
// acc_sha256_compressor: SHA-256 compression core consuming one schedule word per ROUND cycle.
// Defining ACC_COMP_ABORT_EN adds an abort input that drops an in-flight block back to IDLE.
module acc_sha256_compressor
   import acc_sha256_pkg::*;
#(
   parameter int ROUNDS    = 64,
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [255:0]         hash_in,
   input  logic [WORD_SIZE-1:0] w_in,
`ifdef ACC_COMP_ABORT_EN
   input  logic                 abort,
`endif
   output logic                 ms_init,
   output logic                 ms_enable,
   output logic                 busy,
   output logic                 done,
   output logic [255:0]         hash_out
);
   state_t       state_q, state_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [255:0] h_q, h_d, dig_q, dig_d, sum;
   work_t        wv_q, wv_d, wv_nxt;
   logic         last, abort_act;

   acc_sha256_round u_round (
      .wv_i (wv_q),
      .k_i  (K[cnt_q]),
      .w_i  (w_in),
      .wv_o (wv_nxt)
   );

   for (genvar i = 0; i < 8; i++) begin : g_add
      assign sum[32*i +: 32] = h_q[32*i +: 32] + wv_q[32*i +: 32];
   end

`ifdef ACC_COMP_ABORT_EN
   assign abort_act = abort && (state_q inside {LOAD, ROUND, FINAL});
`else
   assign abort_act = 1'b0;
`endif

   assign last      = cnt_q == 6'(ROUNDS - 1);
   assign ms_init   = state_q == LOAD;
   assign ms_enable = state_q == ROUND;
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign hash_out  = dig_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      h_d     = h_q;
      wv_d    = wv_q;
      dig_d   = dig_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            h_d     = hash_in;
            wv_d    = work_t'(hash_in);
         end
         LOAD: begin
            state_d = ROUND;
            cnt_d   = '0;
         end
         ROUND: begin
            wv_d    = wv_nxt;
            state_d = last ? FINAL : ROUND;
            cnt_d   = last ? cnt_q : cnt_q + 6'd1;
         end
         FINAL: begin
            state_d = DONE;
            dig_d   = sum;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // An aborted block must leave the previous digest visible
      if (abort_act) begin
         state_d = IDLE;
         dig_d   = dig_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         h_q     <= '0;
         wv_q    <= '0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         wv_q    <= wv_d;
         dig_q   <= dig_d;
      end
   end
endmodule

// File: tb/tb_acc_sha256_compressor.sv
// tb_acc_sha256_compressor: directed bench with a golden message scheduler and a digest/latency scoreboard.
module tb_acc_sha256_compressor;
   localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_M2    = {480'h0, 32'h000001c0};

   typedef struct {
      string        tag;
      logic [255:0] dig;
      bit           chkd;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, chain = 1'b0;
   logic [255:0] hin = '0, hash_in, hash_out;
   logic [31:0]  w_in;
   logic         ms_init, ms_enable, busy, done;
`ifdef ACC_COMP_ABORT_EN
   logic         abort = 1'b0;
`endif
   logic [31:0]  wmem [64];
   bit   [5:0]   widx;
   int           cyc, n_cmp, n_bad, n_init, n_en, en_run, en_max;
   exp_t         sb [$];

   acc_sha256_compressor dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hash_in   (hash_in),
      .w_in      (w_in),
`ifdef ACC_COMP_ABORT_EN
      .abort     (abort),
`endif
      .ms_init   (ms_init),
      .ms_enable (ms_enable),
      .busy      (busy),
      .done      (done),
      .hash_out  (hash_out)
   );

   always #5 clk = ~clk;
   always_ff @(posedge clk) cyc <= cyc + 1;
   // Golden scheduler: W0 presented in the first ROUND cycle, advanced by ms_enable
   always_ff @(posedge clk) widx <= ms_init ? 6'd0 : ms_enable ? widx + 6'd1 : widx;
   assign w_in    = wmem[widx];
   assign hash_in = chain ? hash_out : hin;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic expand(input logic [511:0] blk);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) wmem[t] = blk[511 - 32*t -: 32];
         else wmem[t] = (ror(wmem[t-2], 17) ^ ror(wmem[t-2], 19) ^ (wmem[t-2] >> 10)) + wmem[t-7]
                      + (ror(wmem[t-15], 7) ^ ror(wmem[t-15], 18) ^ (wmem[t-15] >> 3)) + wmem[t-16];
      end
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic go(input string tag, input logic [255:0] h, input logic [511:0] blk, input logic [255:0] exp, input bit push);
      expand(blk);
      hin   = h;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (push) sb.push_back('{tag: tag, dig: exp, chkd: 1'b1, cyc: cyc + 66});
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 300);
      chk({tag, "_done_seen"}, done, 1);
   endtask

   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (ms_init === 1'b1) n_init++;
         if (ms_enable === 1'b1) begin
            en_run++;
            n_en++;
            if (en_run > en_max) en_max = en_run;
         end else en_run = 0;
         if (done === 1'b1) begin
            chk("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk({e.tag, "_done_cycle"}, cyc, e.cyc);
               if (e.chkd) chk({e.tag, "_digest"}, hash_out, e.dig);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hash", hash_out, 0);
      chk("rst_ctl", {ms_init, ms_enable, busy, done}, 0);
      rst = 1'b0;
      @(negedge clk);
      // "abc": strobe counts, mid-ROUND start ignored, start in DONE ignored
      n_init = 0; n_en = 0; en_max = 0;
      go("abc", IV, BLK_ABC, ABC, 1);
      repeat (30) @(negedge clk);
      chk("abc_busy_mid", busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("abc");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", busy, 0);
      chk("ms_init_cycles", n_init, 1);
      chk("ms_enable_cycles", n_en, 64);
      chk("ms_enable_run", en_max, 64);
      repeat (5) @(negedge clk);
      chk("hash_hold_idle", hash_out, ABC);
      go("empty", IV, BLK_EMPTY, EMPTY, 1);
      wait_done("empty");
      @(negedge clk);
      // Two-block message with start held high; block 2 chains off block 1's digest
      expand(BLK_M1);
      hin   = IV;
      start = 1'b1;
      @(posedge clk);
      #1 chain = 1'b1;
      sb.push_back('{tag: "b2b_1", dig: '0, chkd: 1'b0, cyc: cyc + 66});
      sb.push_back('{tag: "b2b_2", dig: TWO, chkd: 1'b1, cyc: cyc + 134});
      wait_done("b2b_1");
      expand(BLK_M2);
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("b2b_second_accepted", busy, 1);
      wait_done("b2b_2");
      chain = 1'b0;
      @(negedge clk);
      // Reset at round 30 loses the digest
      go("rst_mid", IV, BLK_ABC, ABC, 0);
      repeat (31) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_hash", hash_out, 0);
      chk("rst_mid_ctl", {ms_init, ms_enable, busy, done}, 0);
      rst = 1'b0;
      @(negedge clk);
      go("abc_restart", IV, BLK_ABC, ABC, 1);
      wait_done("abc_restart");
      @(negedge clk);
`ifdef ACC_COMP_ABORT_EN
      go("abort", IV, BLK_EMPTY, EMPTY, 0);
      repeat (11) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ctl", {ms_init, ms_enable, busy, done}, 0);
      chk("abort_hash_kept", hash_out, ABC);
      repeat (80) @(negedge clk);
      abort = 1'b1;
      go("abort_start_idle", IV, BLK_EMPTY, EMPTY, 1);
      abort = 1'b0;
      wait_done("abort_start_idle");
`endif
      repeat (100) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
